// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Multi-channel LED driver. One shared prescaler generates a slow tick and
//   one shared counter generates the PWM ramp. Each channel runs its own mode:
//   OFF, ON, BLINK (toggle per tick), fixed-duty PWM, or BREATHE (triangle
//   duty stepped once per tick).
//
// Ports
//   clk      system clock
//   rst      asynchronous reset, active-high
//   wr_en    write strobe
//   wr_ch    channel index for the write
//   wr_mode  mode code: 0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE (5-7 rejected)
//   wr_duty  duty for PWM mode (always stored)
//   led      registered LED drive, 1 = lit
//   tick     prescaler tick, high one cycle per 2**DIV_W clocks
//   err      registered one-cycle pulse after a rejected write
module led_pattern_gen #(
    parameter int N_LEDS     = 4,
    parameter int CH_W       = 2,
    parameter int DIV_W      = 24,
    parameter int PWM_W      = 8,
    parameter int RESET_MODE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [2:0]        wr_mode,
    input  logic [PWM_W-1:0]  wr_duty,
    output logic [N_LEDS-1:0] led,
    output logic              tick,
    output logic              err
);

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    localparam mode_e            RST_MODE = mode_e'(3'(RESET_MODE));
    localparam logic [PWM_W-1:0] LVL_MAX  = '1;

    logic [DIV_W-1:0]  presc_q,   presc_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    mode_e             mode_q   [N_LEDS];
    mode_e             mode_d   [N_LEDS];
    logic [PWM_W-1:0]  duty_q   [N_LEDS];
    logic [PWM_W-1:0]  duty_d   [N_LEDS];
    logic [PWM_W-1:0]  level_q  [N_LEDS];
    logic [PWM_W-1:0]  level_d  [N_LEDS];
    logic [N_LEDS-1:0] phase_q,  phase_d;
    logic [N_LEDS-1:0] dir_up_q, dir_up_d;
    logic [N_LEDS-1:0] led_q,    led_d;
    logic              err_q,    err_d;
    logic              wr_ok;

    assign tick = (presc_q == '1);
    assign led  = led_q;
    assign err  = err_q;

    always_comb begin
        presc_d   = presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        wr_ok     = wr_en && (int'(wr_ch) < N_LEDS) && (wr_mode <= 3'd4);
        err_d     = wr_en && !wr_ok;
        led_d     = '0;
        phase_d   = phase_q;
        dir_up_d  = dir_up_q;

        for (int unsigned i = 0; i < N_LEDS; i++) begin
            mode_d[i]  = mode_q[i];
            duty_d[i]  = duty_q[i];
            level_d[i] = level_q[i];

            // LED output is a function of the pre-edge state only, so a
            // write shows up on led one edge after it is sampled.
            case (mode_q[i])
                MODE_ON:      led_d[i] = 1'b1;
                MODE_BLINK:   led_d[i] = phase_q[i];
                MODE_PWM:     led_d[i] = (pwm_cnt_q < duty_q[i]);
                MODE_BREATHE: led_d[i] = (pwm_cnt_q < level_q[i]);
                default:      led_d[i] = 1'b0;
            endcase

            // A write beats a coincident tick: the channel restarts cleanly.
            if (wr_ok && (wr_ch == CH_W'(i))) begin
                mode_d[i]   = mode_e'(wr_mode);
                duty_d[i]   = wr_duty;
                level_d[i]  = '0;
                phase_d[i]  = 1'b0;
                dir_up_d[i] = 1'b1;
            end else if (tick) begin
                case (mode_q[i])
                    MODE_BLINK: phase_d[i] = ~phase_q[i];
                    MODE_BREATHE: begin
                        // Direction flips on arrival at an endpoint, so each
                        // endpoint is held for exactly one tick and the level
                        // never wraps.
                        if (dir_up_q[i]) begin
                            level_d[i] = level_q[i] + 1'b1;
                            if (level_q[i] == LVL_MAX - 1'b1) dir_up_d[i] = 1'b0;
                        end else begin
                            level_d[i] = level_q[i] - 1'b1;
                            if (level_q[i] == PWM_W'(1)) dir_up_d[i] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            phase_q   <= '0;
            dir_up_q  <= '1;
            led_q     <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                mode_q[i]  <= RST_MODE;
                duty_q[i]  <= '0;
                level_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            phase_q   <= phase_d;
            dir_up_q  <= dir_up_d;
            led_q     <= led_d;
            err_q     <= err_d;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                mode_q[i]  <= mode_d[i];
                duty_q[i]  <= duty_d[i];
                level_q[i] <= level_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int PW = 4;
    localparam int PERIOD = 1 << PW;   // PWM period and tick period (DW == PW)
    localparam int TMAX   = (1 << PW) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_ch = '0;
    logic [2:0]   wr_mode = '0;
    logic [PW-1:0] wr_duty = '0;
    logic [N-1:0] led;
    logic         tick;
    logic         err;

    int total = 0;
    int bad   = 0;

    // Reference model: time since reset release and ticks since each
    // channel's last (re)start; all outputs derived arithmetically.
    int cyc;
    int mode_m [N];
    int duty_m [N];
    int tcnt   [N];

    led_pattern_gen #(
        .N_LEDS(N), .CH_W(2), .DIV_W(DW), .PWM_W(PW), .RESET_MODE(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_duty(wr_duty),
        .led(led), .tick(tick), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int tri_level(input int t);
        int p;
        p = t % (2 * TMAX);
        return (p <= TMAX) ? p : 2 * TMAX - p;
    endfunction

    function automatic logic model_led(input int i);
        int pwm;
        pwm = cyc % PERIOD;
        case (mode_m[i])
            1:       return 1'b1;
            2:       return logic'(tcnt[i] % 2);
            3:       return pwm < duty_m[i];
            4:       return pwm < tri_level(tcnt[i]);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            mode_m[i] = 2; duty_m[i] = 0; tcnt[i] = 0;
        end
    endtask

    // One clock: drive inputs, predict, advance, compare.
    task automatic step(input logic en, input logic [1:0] ch, input logic [2:0] md, input logic [PW-1:0] dt);
        logic [N-1:0] e_led;
        logic e_err, tk, acc;
        wr_en = en; wr_ch = ch; wr_mode = md; wr_duty = dt;
        tk  = (cyc % PERIOD) == PERIOD - 1;
        for (int i = 0; i < N; i++) e_led[i] = model_led(i);
        acc   = en && (int'(ch) < N) && (md <= 3'd4);
        e_err = en && !acc;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc && int'(ch) == i) begin
                mode_m[i] = int'(md); duty_m[i] = int'(dt); tcnt[i] = 0;
            end else if (tk) begin
                tcnt[i]++;
            end
        end
        wr_en = 1'b0;
        check_val("led",  32'(led),  32'(e_led));
        check_val("err",  32'(err),  32'(e_err));
        check_val("tick", 32'(tick), 32'((cyc % PERIOD) == PERIOD - 1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 3'd0, '0);
    endtask

    initial begin
        int found;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_led", 32'(led), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // reset/blink timing
        idle(15);
        check_val("blink_pre", 32'(led), 32'h0);
        idle(2);
        check_val("blink_on", 32'(led), 32'hF);
        idle(40);

        // PWM duty 4, 0, 15
        step(1'b1, 2'd1, 3'd3, 4'd4);
        idle(40);
        step(1'b1, 2'd1, 3'd3, 4'd0);
        idle(20);
        step(1'b1, 2'd1, 3'd3, 4'd15);
        idle(20);

        // breathe: full triangle plus a bit
        step(1'b1, 2'd2, 3'd4, 4'd0);
        idle(2 * TMAX * PERIOD + 40);

        // rejected / accepted / rejected
        step(1'b1, 2'd3, 3'd6, 4'd0);
        step(1'b1, 2'd3, 3'd1, 4'd0);
        step(1'b1, 2'd0, 3'd7, 4'd0);
        check_val("rej_err1", 32'(err), 32'h1);
        idle(5);

        // write/tick collision on ch0 in BLINK with phase=1
        found = 0;
        for (int k = 0; k < 64 && found == 0; k++) begin
            if ((cyc % PERIOD) == PERIOD - 1 && mode_m[0] == 2 && (tcnt[0] % 2) == 1)
                found = 1;
            else
                idle(1);
        end
        check_val("coll_found", 32'(found), 32'h1);
        step(1'b1, 2'd0, 3'd2, 4'd0);
        step(1'b0, 2'd0, 3'd0, 4'd0);
        check_val("coll_led0", 32'(led[0]), 32'h0);
        idle(20);

        // randomized writes
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0)
                step(1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), PW'($urandom));
            else
                idle(1);
        end

        // async reset mid-breathe
        step(1'b1, 2'd2, 3'd4, 4'd0);
        step(1'b1, 2'd1, 3'd1, 4'd0);
        idle(50);
        step(1'b1, 2'd0, 3'd6, 4'd0);   // err pending high
        #2 rst = 1'b1;
        #1;
        check_val("arst_led",  32'(led),  32'h0);
        check_val("arst_err",  32'(err),  32'h0);
        check_val("arst_tick", 32'(tick), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(15);
        check_val("arst_blink_pre", 32'(led), 32'h0);
        idle(2);
        check_val("arst_blink_on", 32'(led), 32'hF);
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
